// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined immediate extender with valid/ready handshake and 2-entry skid buffer
module imm_ext_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int SHAMT_W  = 5,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [2:0]       ext_op,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_err
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]         state, nxt;
  logic               rdy, accept, xfer;
  logic               load_out, load_skid, skid_to_out;
  logic [SHAMT_W-1:0] sh;
  logic [OUT_W-1:0]   zx, sx, br, zs, ss, ext;
  logic               ext_err;
  logic [OUT_W-1:0]   skid_imm;
  logic [TAG_W-1:0]   skid_tag;
  logic               skid_err;
  assign in_ready = rdy;
  assign accept   = in_valid & rdy;
  assign xfer     = out_valid & out_ready;
  // extend the incoming immediate for every mode, then pick by ext_op
  always_comb begin
    sh      = imm_in[SHAMT_W-1:0];
    zx      = {{(OUT_W-IN_W){1'b0}}, imm_in};
    sx      = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in};
    br      = sx << BR_SHIFT;
    zs      = {{(OUT_W-SHAMT_W){1'b0}}, sh};
    ss      = {{(OUT_W-SHAMT_W){sh[SHAMT_W-1]}}, sh};
    ext_err = ext_op[2] & ext_op[1];
    ext     = ext_op == 3'd0 ? zx :
              ext_op == 3'd1 ? sx :
              ext_op == 3'd2 ? {imm_in, {(OUT_W-IN_W){1'b0}}} :
              ext_op == 3'd3 ? br :
              ext_op == 3'd4 ? zs :
              ext_op == 3'd5 ? ss : '0;
  end
  // occupancy transitions; flush wins over everything and drops a same-cycle accept
  always_comb begin
    nxt         = flush ? EMPTY :
                  state == EMPTY ? (accept ? ONE : EMPTY) :
                  state == ONE ? (accept & ~xfer ? FULL : ~accept & xfer ? EMPTY : ONE) :
                  (xfer ? ONE : FULL);
    load_out    = ~flush & accept & (state == EMPTY | (state == ONE & xfer));
    load_skid   = ~flush & accept & state == ONE & ~xfer;
    skid_to_out = ~flush & xfer & state == FULL;
  end
  // state, registered ready/valid and the output/skid data registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= EMPTY;
      rdy       <= 1'b1;
      out_valid <= 1'b0;
      imm_out   <= '0;
      tag_out   <= '0;
      out_err   <= 1'b0;
      skid_imm  <= '0;
      skid_tag  <= '0;
      skid_err  <= 1'b0;
    end else begin
      state     <= nxt;
      rdy       <= nxt != FULL;
      out_valid <= nxt != EMPTY;
      if (load_out) begin
        imm_out <= ext;
        tag_out <= tag_in;
        out_err <= ext_err;
      end else if (skid_to_out) begin
        imm_out <= skid_imm;
        tag_out <= skid_tag;
        out_err <= skid_err;
      end
      if (load_skid) begin
        skid_imm <= ext;
        skid_tag <= tag_in;
        skid_err <= ext_err;
      end
    end
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the pipelined datapath. It generalises the single-cycle zero/sign extenders to the following modes:
- zero-extend
- sign-extend
- upper-load (LUI)
- branch offset (sign-extend then shift)
- zero- or sign-extended shift amount

Sits between ID decode and the ID/EX operand mux. It uses a valid/ready handshake and a 2-entry skid buffer, so EX back-pressure never drops an operand. A flush input discards in-flight operands on branch/exception.

Parameters:
- IN_W, 16, immediate field width.
- OUT_W, 32, extended operand width; must satisfy OUT_W > IN_W.
- SHAMT_W, 5, shift-amount field width (low bits of imm_in); must satisfy SHAMT_W <= IN_W.
- BR_SHIFT, 2, left shift applied in branch-offset mode.
- TAG_W, 5, sideband tag width (dest register / instruction id), passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  synchronous reset, active low.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  imm_in/ext_op/tag_in valid.
- in_ready  out  1  unit can accept this cycle.
- imm_in  in  IN_W  raw immediate field.
- ext_op  in  3  mode select.
- tag_in  in  TAG_W  sideband.
- out_valid  out  1  imm_out valid.
- out_ready  in  1  consumer accepts this cycle.
- imm_out  out  OUT_W  extended operand.
- tag_out  out  TAG_W  sideband for imm_out.
- out_err  out  1  entry carried an illegal ext_op.

Behaviour:
- Reset: sync on rising clk with rstn=0. The following all clear to 0:
  - state (becomes EMPTY)
  - out_valid, imm_out, tag_out, out_err
  - skid registers
- in_ready=1 from the first cycle after reset release.
- ext_op modes; result computed combinationally at accept, then registered:
  - 0: zero-extend imm_in.
  - 1: sign-extend imm_in.
  - 2: {imm_in, (OUT_W-IN_W) zeros}.
  - 3: sign-extend then << BR_SHIFT, truncated to OUT_W.
  - 4: zero-extend imm_in[SHAMT_W-1:0].
  - 5: sign-extend imm_in[SHAMT_W-1:0].
  - 6,7: imm_out=0, out_err=1.
- Handshakes: input accept = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: exactly 1 cycle from accept to out_valid when EMPTY; entries stay in order.
- State machine:
  - EMPTY: accept -> ONE (output register loaded).
  - ONE: a transfer without an accept -> EMPTY.
  - ONE: an accept without a transfer -> FULL (new entry goes to skid register).
  - ONE: an accept together with a transfer -> ONE (output register reloaded).
  - FULL: a transfer -> ONE (skid entry moves to the output register).
  - FULL: no accept is possible.
- in_ready = (state != FULL), driven from a register, with no combinational path from out_ready.
- Output stability: while out_valid=1 and out_ready=0, imm_out/tag_out/out_err hold.
- flush=1: next state EMPTY, out_valid=0. An input accepted in the same cycle is discarded. flush has priority over all transitions.
- Reset asserted mid-operation: identical to the power-on reset values, and buffered entries are lost.
- Throughput: 1 operand/cycle when out_ready is held high.

Test Plan:
- Reset with rstn=0 for 2 cycles -> out_valid=0, imm_out=0, in_ready=1 after release.
- Mode sweep at out_ready=1:
  - imm_in=0x8001, op0 -> 0x00008001; op1 -> 0xFFFF8001.
  - imm_in=0x1234, op2 -> 0x12340000.
  - imm_in=0xFFFC, op3 -> 0xFFFFFFF0.
  - imm_in=0x001F, op4 -> 0x0000001F; op5 -> 0xFFFFFFFF.
  - op6 -> 0x0 with out_err=1.
  - Each result appears 1 cycle after accept.
- Back-pressure: out_ready=0, send tags 1,2,3 on consecutive cycles -> tags 1,2 accepted, in_ready=0 on the third cycle. Then release out_ready -> outputs arrive in order 1,2, and tag 3 is accepted afterwards.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles -> 8 outputs on consecutive cycles, in order, never FULL.
- Flush in FULL state with a concurrent in_valid -> next cycle out_valid=0, in_ready=1, and no stale entry appears later.
- Reset asserted while FULL -> outputs and state cleared next cycle, with no residual entries after release.
